// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO input front end: interrupt mode encoding
// and the per-pin event decode used by the detect/status logic.
package gpio_pkg;

    localparam int GPIO_NUM_DEF    = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_WIDTH_DEF   = 8;

    // Encoded as {INTTYPE1, INTTYPE0}.
    typedef enum logic [1:0] {
        LVL_HIGH  = 2'b00,
        LVL_LOW   = 2'b01,
        EDGE_RISE = 2'b10,
        EDGE_FALL = 2'b11
    } gpio_int_e;

    function automatic logic detect_event(input gpio_int_e mode,
                                          input logic      filt,
                                          input logic      prev);
        logic ev;
        ev = 1'b0;
        case (mode)
            LVL_HIGH:  ev = filt;
            LVL_LOW:   ev = ~filt;
            EDGE_RISE: ev = filt & ~prev;
            EDGE_FALL: ev = ~filt & prev;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/gpio_sync_deb.sv
// One GPIO pin: multi-flop synchroniser followed by a debounce filter whose
// output only follows the synchronised level after it has been stable thr+1 cycles.
module gpio_sync_deb
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_WIDTH   = DEB_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pad_i,
    input  logic [DEB_WIDTH-1:0] thr_i,
    output logic                 filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DEB_WIDTH-1:0]   cnt_q;
    logic                   filt_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // NOTE: every flop here uses non-blocking assignment so the chain shifts one
    // stage per clock regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // cnt_q only increments while below thr_i, so it can never wrap; the >= compare
    // lets a threshold lowered mid-count take effect on the next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (sync == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q >= thr_i) begin
            filt_q <= sync;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gpio_in_detect.sv
// GPIO input front end: per-pin sync/debounce, then vectorised event detection
// into sticky clear-on-read interrupt status and a flop-driven irq_o.
module gpio_in_detect
    import gpio_pkg::*;
#(
    parameter int GPIO_NUM    = GPIO_NUM_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_WIDTH   = DEB_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [GPIO_NUM-1:0]  gpio_in_i,
    input  logic [DEB_WIDTH-1:0] deb_thr_i,
    input  logic [GPIO_NUM-1:0]  int_en_i,
    input  logic [GPIO_NUM-1:0]  int_type0_i,
    input  logic [GPIO_NUM-1:0]  int_type1_i,
    input  logic                 stat_rd_i,
    output logic [GPIO_NUM-1:0]  padin_o,
    output logic [GPIO_NUM-1:0]  int_stat_o,
    output logic                 irq_o
);

    logic [GPIO_NUM-1:0] filt;
    logic [GPIO_NUM-1:0] prev_q;
    logic [GPIO_NUM-1:0] ev;
    logic [GPIO_NUM-1:0] stat_q;

    for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
        gpio_sync_deb #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_WIDTH   (DEB_WIDTH)
        ) u_sync_deb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .pad_i  (gpio_in_i[i]),
            .thr_i  (deb_thr_i),
            .filt_o (filt[i])
        );
    end

    // NOTE: ev gets a default before the loop so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ev = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            ev[i] = detect_event(gpio_int_e'({int_type1_i[i], int_type0_i[i]}),
                                 filt[i], prev_q[i]);
        end
    end

    // Set wins over clear, so an event coinciding with a read is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            stat_q <= '0;
        end else begin
            prev_q <= filt;
            stat_q <= (stat_q & ~{GPIO_NUM{stat_rd_i}}) | (ev & int_en_i);
        end
    end

    assign padin_o    = filt;
    assign int_stat_o = stat_q;
    assign irq_o      = |stat_q;

endmodule

// File: tb/tb_gpio_in_detect.sv
// Directed bench for gpio_in_detect: debounce latency, glitch rejection, event
// modes, clear-on-read collisions, enable gating and asynchronous reset.
module tb_gpio_in_detect;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] gpio_in_i;
    logic [7:0] deb_thr_i;
    logic [7:0] int_en_i;
    logic [7:0] int_type0_i;
    logic [7:0] int_type1_i;
    logic       stat_rd_i;
    logic [7:0] padin_o;
    logic [7:0] int_stat_o;
    logic       irq_o;

    int n_checks = 0;
    int n_errors = 0;

    gpio_in_detect #(
        .GPIO_NUM    (8),
        .SYNC_STAGES (2),
        .DEB_WIDTH   (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .gpio_in_i   (gpio_in_i),
        .deb_thr_i   (deb_thr_i),
        .int_en_i    (int_en_i),
        .int_type0_i (int_type0_i),
        .int_type1_i (int_type1_i),
        .stat_rd_i   (stat_rd_i),
        .padin_o     (padin_o),
        .int_stat_o  (int_stat_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic rd_pulse();
        stat_rd_i = 1'b1;
        step(1);
        stat_rd_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        gpio_in_i   = 8'h00;
        deb_thr_i   = 8'd0;
        int_en_i    = 8'hFF;
        int_type1_i = 8'hFF;
        int_type0_i = 8'h00;
        stat_rd_i   = 1'b0;
        step(2);
        check("rst_padin", padin_o, 8'h00);
        check("rst_stat", int_stat_o, 8'h00);
        check("rst_irq", irq_o, 1'b0);
        rst_i = 1'b0;
        step(3);

        // 1: thr=0, rising edge on pin0, latency 3, clear on read
        gpio_in_i = 8'h01;
        step(2);
        check("t1_padin_early", padin_o, 8'h00);
        step(1);
        check("t1_padin", padin_o, 8'h01);
        step(1);
        check("t1_stat", int_stat_o, 8'h01);
        check("t1_irq", irq_o, 1'b1);
        rd_pulse();
        check("t1_stat_clr", int_stat_o, 8'h00);
        check("t1_irq_clr", irq_o, 1'b0);
        gpio_in_i = 8'h00;
        step(5);
        check("t1_padin_low", padin_o, 8'h00);
        check("t1_no_fall_ev", int_stat_o, 8'h00);

        // 2: thr=4, 3-cycle glitch rejected, 6-cycle pulse passes after 7 cycles
        deb_thr_i = 8'd4;
        gpio_in_i = 8'h08;
        step(3);
        gpio_in_i = 8'h00;
        step(10);
        check("t2_glitch_padin", padin_o, 8'h00);
        check("t2_glitch_stat", int_stat_o, 8'h00);
        gpio_in_i = 8'h08;
        step(6);
        check("t2_padin_early", padin_o, 8'h00);
        gpio_in_i = 8'h00;
        step(1);
        check("t2_padin_7", padin_o, 8'h08);
        step(1);
        check("t2_stat", int_stat_o, 8'h08);
        step(12);
        check("t2_padin_fall", padin_o, 8'h00);
        rd_pulse();
        check("t2_stat_clr", int_stat_o, 8'h00);

        // 3: pin5 level-low with pad held 0; the level re-sets the bit on a read
        deb_thr_i   = 8'd0;
        int_type1_i = 8'hDF;
        int_type0_i = 8'h20;
        step(1);
        check("t3_stat_set", int_stat_o, 8'h20);
        check("t3_irq", irq_o, 1'b1);
        rd_pulse();
        check("t3_stat_reset", int_stat_o, 8'h20);
        check("t3_irq_kept", irq_o, 1'b1);
        int_en_i = 8'hDF;
        step(2);
        check("t3_en_off_keeps", int_stat_o, 8'h20);

        // 4: pin2 falling edge coincides with a read: bit2 set, bit5 cleared
        int_type0_i = 8'h24;
        gpio_in_i   = 8'h04;
        step(5);
        check("t4_padin_high", padin_o, 8'h04);
        check("t4_no_rise_ev", int_stat_o, 8'h20);
        gpio_in_i = 8'h00;
        step(3);
        check("t4_padin_low", padin_o, 8'h00);
        rd_pulse();
        check("t4_collide", int_stat_o, 8'h04);
        check("t4_irq", irq_o, 1'b1);
        step(1);
        check("t4_sticky", int_stat_o, 8'h04);

        // 5: INTEN=0 blocks sets while padin tracks; enabling with no edges sets nothing
        int_en_i    = 8'h00;
        int_type1_i = 8'hFF;
        int_type0_i = 8'h04;
        rd_pulse();
        check("t5_clr", int_stat_o, 8'h00);
        gpio_in_i = 8'hA5;
        step(3);
        check("t5_padin_a5", padin_o, 8'hA5);
        step(1);
        check("t5_stat_a5", int_stat_o, 8'h00);
        gpio_in_i = 8'h5A;
        step(3);
        check("t5_padin_5a", padin_o, 8'h5A);
        step(1);
        check("t5_stat_5a", int_stat_o, 8'h00);
        int_en_i = 8'hFF;
        step(5);
        check("t5_en_no_edge", int_stat_o, 8'h00);
        check("t5_irq", irq_o, 1'b0);

        // 6: thr=200, reset mid-count on pin7, then a fresh 203-cycle latency
        deb_thr_i   = 8'd200;
        int_type1_i = 8'hFD;
        gpio_in_i   = 8'hDA;
        step(50);
        check("t6_padin_mid", padin_o, 8'h5A);
        check("t6_stat_mid", int_stat_o, 8'h02);
        rst_i = 1'b1;
        #1;
        check("t6_rst_padin", padin_o, 8'h00);
        check("t6_rst_stat", int_stat_o, 8'h00);
        check("t6_rst_irq", irq_o, 1'b0);
        step(2);
        rst_i = 1'b0;
        step(202);
        check("t6_padin_early", padin_o, 8'h00);
        check("t6_stat_early", int_stat_o, 8'h00);
        step(1);
        check("t6_padin", padin_o, 8'hDA);
        step(1);
        check("t6_stat", int_stat_o, 8'hDA);
        check("t6_irq", irq_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
